neokeon_iter_core: RTL and testbench

- Iterative, parametrised Neokeon-128 block cipher core with direct-key encrypt and decrypt modes.
- Runs NROUNDS full rounds followed by the output round: theta with the working key, plus the round-constant XOR.
- Unrolls ROUNDS_PER_CYCLE rounds per clock.
- Valid/ready handshake on both the input and the output side.
- Successor to the combinational last-round stage; top-level cipher datapath.

---
 rtl/neokeon_iter_core_if.sv | 22 ++
 rtl/neokeon_iter_core.sv | 191 +++++++++++++++++++
 tb/tb_neokeon_iter_core.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/neokeon_iter_core_if.sv
// Block/key request and result channels of the Neokeon core; each direction uses valid/ready.
// The core side is "slave": it takes requests in and drives the result out.
interface neokeon_iter_core_if;
    logic         in_valid;
    logic         in_ready;
    logic         in_decrypt;
    logic [127:0] inDataKey;
    logic [127:0] inDataState;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] outDataState;

    modport master (
        output in_valid, in_decrypt, inDataKey, inDataState, out_ready,
        input  in_ready, out_valid, outDataState
    );

    modport slave (
        input  in_valid, in_decrypt, inDataKey, inDataState, out_ready,
        output in_ready, out_valid, outDataState
    );
endinterface

// File: rtl/neokeon_iter_core.sv
// Iterative Neokeon-128 direct-key encrypt/decrypt, ROUNDS_PER_CYCLE rounds per clock; result after NROUNDS/ROUNDS_PER_CYCLE cycles.
// Accepts only in IDLE; the result is held stable in DONE until out_ready, then one idle cycle before the next accept.
module neokeon_iter_core #(
    parameter int NROUNDS          = 16,
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    neokeon_iter_core_if.slave bus
);
    localparam int NCYC  = NROUNDS / ROUNDS_PER_CYCLE;
    localparam int CNT_W = $clog2(NCYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NCYC - 1);

    function automatic logic [7:0] rc_next(input logic [7:0] rc);
        return {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1B : 8'h00);
    endfunction

    function automatic logic [7:0] rc_prev(input logic [7:0] rc);
        return rc[0] ? (((rc ^ 8'h1B) >> 1) | 8'h80) : (rc >> 1);
    endfunction

    function automatic logic [7:0] rc_at(input int n);
        logic [7:0] rc;
        rc = 8'h80;
        for (int i = 0; i < n; i++) rc = rc_next(rc);
        return rc;
    endfunction

    // Decrypt starts from the last constant and walks the sequence backwards.
    localparam logic [7:0] RC_LAST = rc_at(NROUNDS);

    function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [127:0] rc_word(input logic [7:0] rc);
        return {24'h0, rc, 96'h0};
    endfunction

    function automatic logic [127:0] theta(input logic [127:0] s, input logic [127:0] k);
        logic [31:0] a0, a1, a2, a3, t;
        {a0, a1, a2, a3} = s;
        t  = a0 ^ a2;
        t  = t ^ rotl(t, 8) ^ rotl(t, 24);
        a1 = a1 ^ t;
        a3 = a3 ^ t;
        {a0, a1, a2, a3} = {a0, a1, a2, a3} ^ k;
        t  = a1 ^ a3;
        t  = t ^ rotl(t, 8) ^ rotl(t, 24);
        a0 = a0 ^ t;
        a2 = a2 ^ t;
        return {a0, a1, a2, a3};
    endfunction

    function automatic logic [127:0] pi1(input logic [127:0] s);
        return {s[127:96], rotl(s[95:64], 1), rotl(s[63:32], 5), rotl(s[31:0], 2)};
    endfunction

    function automatic logic [127:0] pi2(input logic [127:0] s);
        return {s[127:96], rotl(s[95:64], 31), rotl(s[63:32], 27), rotl(s[31:0], 30)};
    endfunction

    function automatic logic [127:0] gamma(input logic [127:0] s);
        logic [31:0] a0, a1, a2, a3, t;
        {a0, a1, a2, a3} = s;
        a1 = a1 ^ (~a3 & ~a2);
        a0 = a0 ^ (a2 & a1);
        t  = a3;
        a3 = a0;
        a0 = t;
        a2 = a2 ^ a0 ^ a1 ^ a3;
        a1 = a1 ^ (~a3 & ~a2);
        a0 = a0 ^ (a2 & a1);
        return {a0, a1, a2, a3};
    endfunction

    function automatic logic [127:0] enc_round(input logic [127:0] s, input logic [127:0] k,
                                               input logic [7:0] rc);
        return pi2(gamma(pi1(theta(s ^ rc_word(rc), k))));
    endfunction

    function automatic logic [127:0] dec_round(input logic [127:0] s, input logic [127:0] k,
                                               input logic [7:0] rc);
        return pi2(gamma(pi1(theta(s, k) ^ rc_word(rc))));
    endfunction

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [127:0]       r_dat;
    logic [127:0]       r_key;
    logic               r_dec;
    logic [7:0]         r_rc;
    logic [CNT_W-1:0]   r_cnt;
    logic [127:0]       r_out;

    logic               w_in_ready;
    logic               w_out_valid;
    logic               w_accept;
    logic               w_last;
    logic [127:0]       w_st_end;
    logic [7:0]         w_rc_end;
    logic [127:0]       w_fin;

    // Unrolled round chain; stage g feeds stage g+1 within the same cycle.
    for (genvar g = 0; g < ROUNDS_PER_CYCLE; g++) begin : g_rnd
        logic [127:0] w_si;
        logic [127:0] w_so;
        logic [7:0]   w_ri;
        logic [7:0]   w_ro;
        if (g == 0) begin : g_head
            assign w_si = r_dat;
            assign w_ri = r_rc;
        end else begin : g_link
            assign w_si = g_rnd[g-1].w_so;
            assign w_ri = g_rnd[g-1].w_ro;
        end
        assign w_so = r_dec ? dec_round(w_si, r_key, w_ri) : enc_round(w_si, r_key, w_ri);
        assign w_ro = r_dec ? rc_prev(w_ri) : rc_next(w_ri);
    end

    assign w_st_end = g_rnd[ROUNDS_PER_CYCLE-1].w_so;
    assign w_rc_end = g_rnd[ROUNDS_PER_CYCLE-1].w_ro;

    // On the last RUN cycle w_rc_end is RC[NROUNDS] (encrypt) or RC[0] (decrypt).
    assign w_fin = r_dec ? (theta(w_st_end, r_key) ^ rc_word(w_rc_end))
                         : theta(w_st_end ^ rc_word(w_rc_end), r_key);

    assign w_last   = (r_state == S_RUN) && (r_cnt == CNT_LAST);
    assign w_accept = w_in_ready && bus.in_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.in_valid)  w_next = S_RUN;
            S_RUN:   if (w_last)        w_next = S_DONE;
            S_DONE:  if (bus.out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        case (r_state)
            S_IDLE:  w_in_ready  = 1'b1;
            S_DONE:  w_out_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dat <= '0;
            r_key <= '0;
            r_dec <= 1'b0;
            r_rc  <= '0;
            r_cnt <= '0;
            r_out <= '0;
        end else if (w_accept) begin
            r_dat <= bus.inDataState;
            r_key <= bus.in_decrypt ? theta(bus.inDataKey, 128'h0) : bus.inDataKey;
            r_dec <= bus.in_decrypt;
            r_rc  <= bus.in_decrypt ? RC_LAST : 8'h80;
            r_cnt <= '0;
        end else if (r_state == S_RUN) begin
            r_dat <= w_st_end;
            r_rc  <= w_rc_end;
            r_cnt <= r_cnt + 1'b1;
            if (w_last) r_out <= w_fin;
        end
    end

    assign bus.in_ready     = w_in_ready;
    assign bus.out_valid    = w_out_valid;
    assign bus.outDataState = r_out;
endmodule

// File: tb/tb_neokeon_iter_core.sv
// Drives four builds (1, 2, 4, 16 rounds per clock) in lockstep and checks them against a word-level Neokeon model.
module tb_neokeon_iter_core;
    localparam int NINST = 4;
    localparam logic [127:0] KAT_CT = 128'hb1656851699e29fa24b70148503d2dfc;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_decrypt;
    logic [127:0] in_key;
    logic [127:0] in_dat;
    logic         out_ready;

    logic         inst_in_ready  [NINST];
    logic         inst_out_valid [NINST];
    logic [127:0] inst_out       [NINST];

    int           lat_exp [NINST];
    logic [127:0] res     [NINST];
    int           lat     [NINST];
    logic [7:0]   rc_tab  [0:16];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NINST; g++) begin : g_dut
        localparam int RPC = (g == 3) ? 16 : (1 << g);
        neokeon_iter_core_if bus ();
        assign bus.in_valid    = in_valid;
        assign bus.in_decrypt  = in_decrypt;
        assign bus.inDataKey   = in_key;
        assign bus.inDataState = in_dat;
        assign bus.out_ready   = out_ready;
        assign inst_in_ready[g]  = bus.in_ready;
        assign inst_out_valid[g] = bus.out_valid;
        assign inst_out[g]       = bus.outDataState;
        neokeon_iter_core #(.NROUNDS(16), .ROUNDS_PER_CYCLE(RPC)) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus)
        );
    end

    // ---------------- reference model (32-bit word arrays) ----------------
    function automatic logic [31:0] rol(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [127:0] m_theta(input logic [127:0] s, input logic [127:0] key);
        logic [31:0] a [4];
        logic [31:0] t;
        for (int i = 0; i < 4; i++) a[i] = s[127-32*i -: 32];
        t = a[0] ^ a[2];
        t = t ^ rol(t, 8) ^ ror(t, 8);
        a[1] ^= t;
        a[3] ^= t;
        for (int i = 0; i < 4; i++) a[i] ^= key[127-32*i -: 32];
        t = a[1] ^ a[3];
        t = t ^ rol(t, 8) ^ ror(t, 8);
        a[0] ^= t;
        a[2] ^= t;
        return {a[0], a[1], a[2], a[3]};
    endfunction

    function automatic logic [127:0] m_pi(input logic [127:0] s, input bit inv);
        logic [31:0] a [4];
        int          sh [4];
        sh = '{0, 1, 5, 2};
        for (int i = 0; i < 4; i++) begin
            a[i] = s[127-32*i -: 32];
            if (i != 0) a[i] = inv ? ror(a[i], sh[i]) : rol(a[i], sh[i]);
        end
        return {a[0], a[1], a[2], a[3]};
    endfunction

    function automatic logic [127:0] m_gamma(input logic [127:0] s);
        logic [31:0] a [4];
        logic [31:0] t;
        for (int i = 0; i < 4; i++) a[i] = s[127-32*i -: 32];
        a[1] ^= ~a[3] & ~a[2];
        a[0] ^= a[2] & a[1];
        t = a[3]; a[3] = a[0]; a[0] = t;
        a[2] ^= a[0] ^ a[1] ^ a[3];
        a[1] ^= ~a[3] & ~a[2];
        a[0] ^= a[2] & a[1];
        return {a[0], a[1], a[2], a[3]};
    endfunction

    function automatic logic [127:0] neokeon_ref(input bit dec, input logic [127:0] k,
                                                 input logic [127:0] d);
        logic [127:0] s;
        logic [127:0] kw;
        s  = d;
        kw = dec ? m_theta(k, 128'h0) : k;
        for (int r = 0; r < 16; r++) begin
            if (dec) begin
                s = m_theta(s, kw);
                s[103:96] ^= rc_tab[16-r];
            end else begin
                s[103:96] ^= rc_tab[r];
                s = m_theta(s, kw);
            end
            s = m_pi(m_gamma(m_pi(s, 1'b0)), 1'b1);
        end
        if (dec) begin
            s = m_theta(s, kw);
            s[103:96] ^= rc_tab[0];
        end else begin
            s[103:96] ^= rc_tab[16];
            s = m_theta(s, kw);
        end
        return s;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One block through all builds; inputs are scrambled while the builds are busy.
    task automatic run_block(input bit dec, input logic [127:0] k, input logic [127:0] d);
        int guard;
        bit all_rdy;
        bit unstable [NINST];
        guard   = 0;
        all_rdy = 1'b0;
        while (!all_rdy && guard < 50) begin
            all_rdy = 1'b1;
            for (int i = 0; i < NINST; i++) if (inst_in_ready[i] !== 1'b1) all_rdy = 1'b0;
            if (!all_rdy) begin
                tick();
                guard++;
            end
        end
        checks++;
        if (!all_rdy) begin
            errors++;
            $display("FAIL idle_wait: in_ready not high on all builds after %0d cycles", guard);
        end
        for (int i = 0; i < NINST; i++) begin
            res[i] = '0;
            lat[i] = 0;
            unstable[i] = 1'b0;
        end
        in_valid = 1'b1; in_decrypt = dec; in_key = k; in_dat = d; out_ready = 1'b0;
        tick();
        for (int c = 1; c <= 20; c++) begin
            in_valid   = 1'($urandom_range(0, 1));
            in_decrypt = 1'($urandom_range(0, 1));
            in_key     = rnd128();
            in_dat     = rnd128();
            tick();
            for (int i = 0; i < NINST; i++) begin
                if (lat[i] == 0 && inst_out_valid[i] === 1'b1) begin
                    lat[i] = c;
                    res[i] = inst_out[i];
                end else if (lat[i] != 0 && inst_out[i] !== res[i]) begin
                    unstable[i] = 1'b1;
                end
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < NINST; i++) begin
            checks++;
            if (lat[i] != lat_exp[i]) begin
                errors++;
                $display("FAIL latency[%0d]: got %0d cycles, expected %0d", i, lat[i], lat_exp[i]);
            end
            checks++;
            if (unstable[i] || inst_out_valid[i] !== 1'b0) begin
                errors++;
                $display("FAIL hold[%0d]: unstable=%0d out_valid_after_handshake=%b, expected 0/0",
                         i, unstable[i], inst_out_valid[i]);
            end
        end
    endtask

    task automatic wait_valid0(input string tag);
        int guard;
        guard = 0;
        while (inst_out_valid[0] !== 1'b1 && guard < 40) begin
            tick();
            guard++;
        end
        checks++;
        if (inst_out_valid[0] !== 1'b1) begin
            errors++;
            $display("FAIL %s: out_valid=%b after %0d cycles, expected 1", tag, inst_out_valid[0], guard);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_decrypt = 1'b0; in_key = '0; in_dat = '0; out_ready = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < NINST; i++) begin
            checks++;
            if (inst_in_ready[i] !== 1'b1 || inst_out_valid[i] !== 1'b0 || inst_out[i] !== 128'h0) begin
                errors++;
                $display("FAIL reset[%0d]: in_ready=%b out_valid=%b out=%h, expected 1/0/0",
                         i, inst_in_ready[i], inst_out_valid[i], inst_out[i]);
            end
        end
    endtask

    task automatic test_known_vector();
        run_block(1'b0, 128'h0, 128'h0);
        for (int i = 0; i < NINST; i++) begin
            checks++;
            if (res[i] !== KAT_CT) begin
                errors++;
                $display("FAIL kat_enc[%0d]: got %h, expected %h", i, res[i], KAT_CT);
            end
        end
        run_block(1'b1, 128'h0, KAT_CT);
        for (int i = 0; i < NINST; i++) begin
            checks++;
            if (res[i] !== 128'h0) begin
                errors++;
                $display("FAIL kat_dec[%0d]: got %h, expected 0", i, res[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [127:0] k, p, c;
        for (int n = 0; n < 200; n++) begin
            k = rnd128();
            p = rnd128();
            c = neokeon_ref(1'b0, k, p);
            run_block(1'b0, k, p);
            for (int i = 0; i < NINST; i++) begin
                checks++;
                if (res[i] !== c) begin
                    errors++;
                    $display("FAIL rand_enc[%0d] #%0d: got %h, expected %h", i, n, res[i], c);
                end
            end
            run_block(1'b1, k, c);
            for (int i = 0; i < NINST; i++) begin
                checks++;
                if (res[i] !== p) begin
                    errors++;
                    $display("FAIL rand_dec[%0d] #%0d: got %h, expected %h", i, n, res[i], p);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] k, p, c, k2, p2;
        k = rnd128(); p = rnd128(); c = neokeon_ref(1'b0, k, p);
        k2 = rnd128(); p2 = rnd128();
        in_valid = 1'b1; in_decrypt = 1'b0; in_key = k; in_dat = p; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        wait_valid0("bp_first_valid");
        for (int c2 = 0; c2 < 10; c2++) begin
            in_valid   = ~in_valid;
            in_dat     = rnd128();
            in_key     = rnd128();
            in_decrypt = 1'($urandom_range(0, 1));
            tick();
            checks++;
            if (inst_in_ready[0] !== 1'b0 || inst_out_valid[0] !== 1'b1 || inst_out[0] !== c) begin
                errors++;
                $display("FAIL bp_hold cycle %0d: in_ready=%b out_valid=%b out=%h, expected 0/1/%h",
                         c2, inst_in_ready[0], inst_out_valid[0], inst_out[0], c);
            end
        end
        in_valid = 1'b1; in_decrypt = 1'b0; in_key = k2; in_dat = p2; out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (inst_out_valid[0] !== 1'b0 || inst_in_ready[0] !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: out_valid=%b in_ready=%b, expected 0/1",
                     inst_out_valid[0], inst_in_ready[0]);
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if (inst_in_ready[0] !== 1'b0) begin
            errors++;
            $display("FAIL bp_accept_next: in_ready=%b, expected 0", inst_in_ready[0]);
        end
        wait_valid0("bp_second_valid");
        checks++;
        if (inst_out[0] !== neokeon_ref(1'b0, k2, p2)) begin
            errors++;
            $display("FAIL bp_second_ct: got %h, expected %h", inst_out[0], neokeon_ref(1'b0, k2, p2));
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        logic [127:0] k, p;
        k = rnd128(); p = rnd128();
        in_valid = 1'b1; in_decrypt = 1'b0; in_key = k; in_dat = p; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        repeat (7) tick();
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < NINST; i++) begin
            checks++;
            if (inst_in_ready[i] !== 1'b1 || inst_out_valid[i] !== 1'b0 || inst_out[i] !== 128'h0) begin
                errors++;
                $display("FAIL mid_reset[%0d]: in_ready=%b out_valid=%b out=%h, expected 1/0/0",
                         i, inst_in_ready[i], inst_out_valid[i], inst_out[i]);
            end
        end
        tick();
        rst_n = 1'b1;
        tick();
        run_block(1'b0, k, p);
        for (int i = 0; i < NINST; i++) begin
            checks++;
            if (res[i] !== neokeon_ref(1'b0, k, p)) begin
                errors++;
                $display("FAIL post_reset_ct[%0d]: got %h, expected %h", i, res[i], neokeon_ref(1'b0, k, p));
            end
        end
    endtask

    task automatic test_back_to_back();
        int           acc_t [$];
        logic [127:0] expq  [$];
        logic [127:0] e;
        bit           acc;
        in_valid = 1'b1; in_decrypt = 1'b0; in_key = rnd128(); in_dat = rnd128(); out_ready = 1'b1;
        for (int c = 0; c < 110; c++) begin
            if (c == 80) in_valid = 1'b0;
            acc = (inst_in_ready[0] === 1'b1) && in_valid;
            if (acc) begin
                acc_t.push_back(c);
                expq.push_back(neokeon_ref(1'b0, in_key, in_dat));
            end
            tick();
            if (acc) begin
                in_key = rnd128();
                in_dat = rnd128();
            end
            if (inst_out_valid[0] === 1'b1) begin
                checks++;
                if (expq.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_spurious: out_valid with no block pending at cycle %0d", c);
                end else begin
                    e = expq.pop_front();
                    if (inst_out[0] !== e) begin
                        errors++;
                        $display("FAIL b2b_ct: got %h, expected %h", inst_out[0], e);
                    end
                end
            end
        end
        out_ready = 1'b0;
        checks++;
        if (acc_t.size() != 5 || expq.size() != 0) begin
            errors++;
            $display("FAIL b2b_count: accepts=%0d pending=%0d, expected 5/0", acc_t.size(), expq.size());
        end
        for (int j = 1; j < acc_t.size(); j++) begin
            checks++;
            if (acc_t[j] - acc_t[j-1] != 18) begin
                errors++;
                $display("FAIL b2b_spacing %0d: got %0d cycles, expected 18", j, acc_t[j] - acc_t[j-1]);
            end
        end
    endtask

    initial begin
        rc_tab[0] = 8'h80;
        for (int i = 1; i <= 16; i++)
            rc_tab[i] = {rc_tab[i-1][6:0], 1'b0} ^ (rc_tab[i-1][7] ? 8'h1B : 8'h00);
        lat_exp[0] = 16; lat_exp[1] = 8; lat_exp[2] = 4; lat_exp[3] = 1;

        test_reset();
        test_known_vector();
        test_random();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
